// File: rtl/aes_decrypt_top.sv
// Iterative AES-128 inverse cipher: forward key expansion, then one inverse round per cycle; 21 cycles capture-to-result.
// No backpressure: AES_en is only sampled in IDLE, never queued; the result holds until the next completion or reset.
module aes_decrypt_top (
    input  logic         AES_clk,
    input  logic         AES_rst,
    input  logic         AES_en,
    input  logic [127:0] AES_data_in,
    input  logic [127:0] AES_key_in,
    output logic [127:0] AES_data_out,
    output logic         AES_data_out_valid,
    output logic         AES_busy
);

    typedef enum logic [2:0] {IDLE, KEXP, INIT, ROUND, FINAL} state_t;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] b);
        logic [7:0] o;
        for (int i = 0; i < 8; i++)
            o[i] = b[(i + 2) % 8] ^ b[(i + 5) % 8] ^ b[(i + 7) % 8];
        return o ^ 8'h05;
    endfunction

    // Inverse S-box built around the forward table so both paths share one ROM shape
    function automatic logic [7:0] inv_sub(input logic [7:0] b);
        return inv_affine(sbox(inv_affine(b)));
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] m2, m4, m8;
        m2 = xtime(b);
        m4 = xtime(m2);
        m8 = xtime(m4);
        return (k[3] ? m8 : 8'h00) ^ (k[2] ? m4 : 8'h00) ^ (k[1] ? m2 : 8'h00) ^ (k[0] ? b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
                gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
                gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
                gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            o[127 - 32 * c -: 32] = inv_mix_col(s[127 - 32 * c -: 32]);
        return o;
    endfunction

    // Row r rotates right by r: out[r][c] = in[r][c-r]
    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8 * (4 * c + r) -: 8] = inv_sub(s[127 - 8 * (4 * ((c + 4 - r) % 4) + r) -: 8]);
        return o;
    endfunction

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] fwd_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h0};
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] inv_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n3 = k[31:0] ^ k[63:32];
        n2 = k[63:32] ^ k[95:64];
        n1 = k[95:64] ^ k[127:96];
        n0 = k[127:96] ^ sub_rot(n3) ^ {rc, 24'h0};
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [7:0] rcon_prev(input logic [7:0] r);
        return (r == 8'h1b) ? 8'h80 : {1'b0, r[7:1]};
    endfunction

    state_t         r_state, w_state_nxt;
    logic [127:0]   r_data, w_data_nxt;
    logic [127:0]   r_key, w_key_nxt;
    logic [7:0]     r_rcon, w_rcon_nxt;
    logic [3:0]     r_cnt, w_cnt_nxt;
    logic [127:0]   r_out, w_out_nxt;
    logic           r_valid, w_valid_nxt;
    logic           r_busy, w_busy_nxt;

    logic [127:0]   w_iss;
    logic [127:0]   w_key_fwd;
    logic [127:0]   w_key_inv;

    assign w_iss     = inv_shift_sub(r_data) ^ r_key;
    assign w_key_fwd = fwd_step(r_key, r_rcon);
    assign w_key_inv = inv_step(r_key, r_rcon);

    always_ff @(posedge AES_clk) begin
        if (AES_rst) begin
            r_state <= IDLE;
            r_data  <= 128'h0;
            r_key   <= 128'h0;
            r_rcon  <= 8'h01;
            r_cnt   <= 4'd0;
            r_out   <= 128'h0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_key   <= w_key_nxt;
            r_rcon  <= w_rcon_nxt;
            r_cnt   <= w_cnt_nxt;
            r_out   <= w_out_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_key_nxt   = r_key;
        w_rcon_nxt  = r_rcon;
        w_cnt_nxt   = r_cnt;
        w_out_nxt   = r_out;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = r_busy;
        case (r_state)
            IDLE: begin
                w_busy_nxt = 1'b0;
                if (AES_en) begin
                    w_data_nxt  = AES_data_in;
                    w_key_nxt   = AES_key_in;
                    w_rcon_nxt  = 8'h01;
                    w_cnt_nxt   = 4'd0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = KEXP;
                end
            end
            KEXP: begin
                w_key_nxt = w_key_fwd;
                // rcon stays at 0x36 after the last step so INIT can undo rk10 with it
                if (r_cnt == 4'd9) begin
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = INIT;
                end else begin
                    w_cnt_nxt  = r_cnt + 4'd1;
                    w_rcon_nxt = xtime(r_rcon);
                end
            end
            INIT: begin
                w_data_nxt  = r_data ^ r_key;
                w_key_nxt   = w_key_inv;
                w_rcon_nxt  = rcon_prev(r_rcon);
                w_cnt_nxt   = 4'd0;
                w_state_nxt = ROUND;
            end
            ROUND: begin
                w_data_nxt = inv_mix(w_iss);
                w_key_nxt  = w_key_inv;
                w_rcon_nxt = rcon_prev(r_rcon);
                if (r_cnt == 4'd8) begin
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = FINAL;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            FINAL: begin
                w_out_nxt   = w_iss;
                w_valid_nxt = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign AES_data_out       = r_out;
    assign AES_data_out_valid = r_valid;
    assign AES_busy           = r_busy;

endmodule
